// File: rtl/uart_tx_buffered_if.sv
// Byte-write handshake and line/status signals of the buffered UART transmitter.
interface uart_tx_buffered_if;
  logic       i_TX_DV;
  logic [7:0] i_TX_Byte;
  logic       o_TX_Ready;
  logic       o_Overflow;
  logic       o_TX_Active;
  logic       o_TX_Done;
  logic       o_TX_Serial;

  modport master (
    output i_TX_DV, i_TX_Byte,
    input  o_TX_Ready, o_Overflow, o_TX_Active, o_TX_Done, o_TX_Serial
  );

  modport slave (
    input  i_TX_DV, i_TX_Byte,
    output o_TX_Ready, o_Overflow, o_TX_Active, o_TX_Done, o_TX_Serial
  );
endinterface

// File: rtl/uart_tx_buffered.sv
// 8N1 UART transmitter fed by a small FIFO; frames leave LSB-first, back-to-back when queued.
//  state | meaning
//  IDLE  | line high, waiting for a queued byte
//  START | start bit (low) for one bit period
//  DATA  | eight data bits, LSB first
//  STOP  | stop bit (high); pops the next byte on its last cycle if one is queued
module uart_tx_buffered #(
  parameter int CLKS_PER_BIT = 217,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic               i_Clk,
  input  logic               i_Rst_L,
  uart_tx_buffered_if.slave  tx
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int BW = $clog2(CLKS_PER_BIT);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q, count_d;
  logic          full, empty, wr_en, pop;
  logic          ovf_q, ready_q;

  state_t        state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          serial_q, serial_d;
  logic          active_q, active_d;
  logic          done_q, done_d;
  logic          baud_end;

  // Fullness is judged on the start-of-cycle count, so a same-cycle pop never frees a slot.
  assign full     = (count_q == (AW+1)'(FIFO_DEPTH));
  assign empty    = (count_q == '0);
  assign wr_en    = tx.i_TX_DV && !full;
  assign baud_end = (baud_q == BW'(CLKS_PER_BIT - 1));

  always_comb begin
    count_d = count_q;
    case ({wr_en, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge i_Clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= tx.i_TX_Byte;
  end

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      ready_q  <= 1'b1;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)   rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
      ovf_q   <= tx.i_TX_DV && full;
      ready_q <= (count_d != (AW+1)'(FIFO_DEPTH));
    end
  end

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state_q  <= IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      serial_q <= 1'b1;
      active_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      serial_q <= serial_d;
      active_q <= active_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    baud_d   = baud_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    serial_d = serial_q;
    active_d = active_q;
    done_d   = 1'b0;
    pop      = 1'b0;
    case (state_q)
      IDLE: begin
        serial_d = 1'b1;
        active_d = 1'b0;
        if (!empty) begin
          pop      = 1'b1;
          shift_d  = mem_q[rd_ptr_q];
          baud_d   = '0;
          state_d  = START;
          serial_d = 1'b0;
          active_d = 1'b1;
        end
      end
      START: begin
        if (baud_end) begin
          baud_d   = '0;
          bit_d    = '0;
          state_d  = DATA;
          serial_d = shift_q[0];
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      DATA: begin
        if (baud_end) begin
          baud_d = '0;
          if (bit_q == 3'd7) begin
            state_d  = STOP;
            serial_d = 1'b1;
          end else begin
            bit_d    = bit_q + 3'd1;
            serial_d = shift_q[bit_q + 3'd1];
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      STOP: begin
        if (baud_end) begin
          baud_d = '0;
          done_d = 1'b1;
          // A queued byte starts its frame on the very next cycle: no idle gap.
          if (!empty) begin
            pop      = 1'b1;
            shift_d  = mem_q[rd_ptr_q];
            state_d  = START;
            serial_d = 1'b0;
          end else begin
            state_d  = IDLE;
            active_d = 1'b0;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign tx.o_TX_Ready  = ready_q;
  assign tx.o_Overflow  = ovf_q;
  assign tx.o_TX_Active = active_q;
  assign tx.o_TX_Done   = done_q;
  assign tx.o_TX_Serial = serial_q;
endmodule

// File: tb/tb_uart_tx_buffered.sv
// Directed bench for uart_tx_buffered: frame vectors, bursts, overflow, reset abort, full-rate timing.
module tb_uart_tx_buffered;
  localparam int CPB = 4;
  localparam int BIG = 217;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  uart_tx_buffered_if mif ();
  uart_tx_buffered_if bif ();

  uart_tx_buffered #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(4)) dut (
    .i_Clk(clk), .i_Rst_L(rst_n), .tx(mif)
  );
  uart_tx_buffered #(.CLKS_PER_BIT(BIG), .FIFO_DEPTH(4)) dut_big (
    .i_Clk(clk), .i_Rst_L(rst_n), .tx(bif)
  );

  typedef struct {
    logic [7:0] data;
    logic [9:0] frame;  // bit0 = start, bits1..8 = data LSB first, bit9 = stop
  } vec_t;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int act_cnt  = 0;
  int ovf_cnt  = 0;
  int done_q [$];
  int start_q [$];
  logic [9:0] rx_q [$];
  logic [9:0] exp_q [$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (mif.o_TX_Active) act_cnt++;
    if (mif.o_Overflow) ovf_cnt++;
    if (mif.o_TX_Done) done_q.push_back(cyc);
  end

  // Independent line decoder: samples mid-bit, discards any frame touched by reset.
  initial begin
    logic [9:0] fr;
    logic ok;
    int sc;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && mif.o_TX_Serial === 1'b0) begin
        sc = cyc;
        ok = 1'b1;
        fr = '0;
        for (int b = 0; b < 10; b++) begin
          repeat ((b == 0) ? CPB / 2 : CPB) @(negedge clk);
          if (rst_n !== 1'b1) ok = 1'b0;
          fr[b] = mif.o_TX_Serial;
        end
        if (ok) begin
          rx_q.push_back(fr);
          start_q.push_back(sc);
        end
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic clear_mon();
    rx_q.delete();
    start_q.delete();
    done_q.delete();
    act_cnt = 0;
    ovf_cnt = 0;
  endtask

  // Returns #1 after the pop edge, having checked the two-edge start latency.
  task automatic write_byte(input logic [7:0] b);
    @(posedge clk); #1;
    mif.i_TX_DV = 1'b1; mif.i_TX_Byte = b;
    @(posedge clk); #1;
    mif.i_TX_DV = 1'b0;
    @(negedge clk);
    check("latency_line_still_idle", int'(mif.o_TX_Serial), 1);
    @(posedge clk); #1;
    check("latency_start_bit", int'(mif.o_TX_Serial), 0);
    check("latency_active", int'(mif.o_TX_Active), 1);
  endtask

  // Writes base, base+1, ... on n consecutive edges; returns #1 after the last write edge.
  task automatic write_burst(input int n, input logic [7:0] base);
    @(posedge clk); #1;
    mif.i_TX_DV = 1'b1; mif.i_TX_Byte = base;
    for (int i = 1; i < n; i++) begin
      @(posedge clk); #1;
      mif.i_TX_Byte = base + 8'(i);
    end
    @(posedge clk); #1;
    mif.i_TX_DV = 1'b0;
  endtask

  task automatic wait_idle(input int max);
    int n = 0;
    while (mif.o_TX_Active && n < max) begin
      @(negedge clk);
      n++;
    end
    check("idle_reached_in_budget", int'(n < max), 1);
    repeat (2) @(negedge clk);
    #1;
  endtask

  task automatic check_frames(input string name);
    check({name, "_frame_count"}, rx_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++)
      check({name, "_frame"}, int'(rx_q[i]), int'(exp_q[i]));
  endtask

  vec_t vecs [5];

  initial begin
    int n, lo, hi;
    logic [7:0] rxb;

    vecs[0] = '{data: 8'hA5, frame: 10'b1101001010};
    vecs[1] = '{data: 8'h00, frame: 10'b1000000000};
    vecs[2] = '{data: 8'hFF, frame: 10'b1111111110};
    vecs[3] = '{data: 8'h3C, frame: 10'b1001111000};
    vecs[4] = '{data: 8'h81, frame: 10'b1100000010};

    rst_n = 1'b0;
    mif.i_TX_DV = 1'b0; mif.i_TX_Byte = '0;
    bif.i_TX_DV = 1'b0; bif.i_TX_Byte = '0;
    repeat (3) @(negedge clk);
    check("rst_serial", int'(mif.o_TX_Serial), 1);
    check("rst_ready", int'(mif.o_TX_Ready), 1);
    check("rst_active", int'(mif.o_TX_Active), 0);
    check("rst_done", int'(mif.o_TX_Done), 0);
    check("rst_overflow", int'(mif.o_Overflow), 0);
    check("rst_big_serial", int'(bif.o_TX_Serial), 1);
    check("rst_big_ready", int'(bif.o_TX_Ready), 1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);

    // Single-frame vectors.
    for (int v = 0; v < 5; v++) begin
      clear_mon();
      write_byte(vecs[v].data);
      wait_idle(80);
      exp_q.delete();
      exp_q.push_back(vecs[v].frame);
      check_frames("single");
      check("single_active_cycles", act_cnt, 40);
      check("single_done_pulses", done_q.size(), 1);
    end

    // Three queued bytes: contiguous frames.
    clear_mon();
    write_burst(3, 8'h01);
    wait_idle(200);
    exp_q.delete();
    exp_q.push_back(10'b1000000010);
    exp_q.push_back(10'b1000000100);
    exp_q.push_back(10'b1000000110);
    check_frames("burst3");
    check("burst3_active_cycles", act_cnt, 120);
    check("burst3_done_pulses", done_q.size(), 3);
    if (done_q.size() == 3) begin
      check("burst3_done_spacing_a", done_q[1] - done_q[0], 40);
      check("burst3_done_spacing_b", done_q[2] - done_q[1], 40);
    end
    if (start_q.size() == 3) begin
      check("burst3_start_spacing_a", start_q[1] - start_q[0], 40);
      check("burst3_start_spacing_b", start_q[2] - start_q[1], 40);
    end

    // Six writes into a depth-4 FIFO: first is popped, four fill, sixth is dropped.
    clear_mon();
    write_burst(6, 8'h10);
    @(negedge clk);
    check("ovf6_overflow_pulse", int'(mif.o_Overflow), 1);
    check("ovf6_ready_low", int'(mif.o_TX_Ready), 0);
    @(negedge clk);
    check("ovf6_overflow_single", int'(mif.o_Overflow), 0);
    wait_idle(300);
    exp_q.delete();
    exp_q.push_back(10'b1000100000);
    exp_q.push_back(10'b1000100010);
    exp_q.push_back(10'b1000100100);
    exp_q.push_back(10'b1000100110);
    exp_q.push_back(10'b1000101000);
    check_frames("ovf6");
    check("ovf6_overflow_count", ovf_cnt, 1);
    check("ovf6_ready_after", int'(mif.o_TX_Ready), 1);

    // Write to a full FIFO on the same edge the FSM pops the next byte.
    clear_mon();
    write_burst(5, 8'h20);
    repeat (36) @(posedge clk);
    #1;
    mif.i_TX_DV = 1'b1; mif.i_TX_Byte = 8'h99;
    @(negedge clk);
    check("popfull_ready_low_before", int'(mif.o_TX_Ready), 0);
    @(posedge clk); #1;
    mif.i_TX_DV = 1'b0;
    @(negedge clk);
    check("popfull_overflow", int'(mif.o_Overflow), 1);
    check("popfull_ready_after_pop", int'(mif.o_TX_Ready), 1);
    check("popfull_next_frame_started", int'(mif.o_TX_Serial), 0);
    wait_idle(300);
    exp_q.delete();
    exp_q.push_back(10'b1001000000);
    exp_q.push_back(10'b1001000010);
    exp_q.push_back(10'b1001000100);
    exp_q.push_back(10'b1001000110);
    exp_q.push_back(10'b1001001000);
    check_frames("popfull");
    check("popfull_overflow_count", ovf_cnt, 1);

    // Reset during data bit 3 of 0x5A (bit 3 = 1, so force it while the line is high would hide it; check bit 2 phase too).
    clear_mon();
    write_byte(8'h5A);
    repeat (17) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("rstmid_serial_high", int'(mif.o_TX_Serial), 1);
    check("rstmid_active_low", int'(mif.o_TX_Active), 0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    clear_mon();
    hi = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (mif.o_TX_Serial) hi++;
    end
    #1;
    check("rstmid_line_idle_after", hi, 60);
    check("rstmid_no_frames", rx_q.size(), 0);
    check("rstmid_no_done", done_q.size(), 0);
    check("rstmid_no_active", act_cnt, 0);
    check("rstmid_ready", int'(mif.o_TX_Ready), 1);

    // Full-rate instance, byte 0x00.
    @(posedge clk); #1;
    bif.i_TX_DV = 1'b1; bif.i_TX_Byte = 8'h00;
    @(posedge clk); #1;
    bif.i_TX_DV = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bif.o_TX_Serial && n < 10);
    check("big_start_found", int'(bif.o_TX_Serial), 0);
    lo = 0;
    rxb = 8'hFF;
    while (!bif.o_TX_Serial && lo < 3000) begin
      for (int k = 1; k <= 8; k++)
        if (lo == BIG * k + BIG / 2) rxb[k-1] = bif.o_TX_Serial;
      lo++;
      @(negedge clk);
    end
    check("big_low_cycles", lo, 9 * BIG);
    check("big_rx_byte", int'(rxb), 0);
    hi = 0;
    while (bif.o_TX_Serial && bif.o_TX_Active && hi < 500) begin
      hi++;
      @(negedge clk);
    end
    check("big_stop_cycles", hi, BIG);
    check("big_done_pulse", int'(bif.o_TX_Done), 1);
    check("big_line_idle", int'(bif.o_TX_Serial), 1);
    @(negedge clk);
    check("big_done_single", int'(bif.o_TX_Done), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
